// File: rtl/stepmotor_seq.sv
// stepmotor_seq: counted-move sequencer for a 4-phase unipolar stepper.
// Accepts move commands (dir/steps/speed) on a valid/ready handshake, times each
// step, drives the L1..L4 coil pattern and tracks signed absolute position.
//
// Parameters:
//   BASE_TICKS  clk cycles per speed unit; step period = BASE_TICKS*(speed+1)
//   HOLD        1 = keep last coil pattern while idle, 0 = coils off while idle
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_dir               1 = forward (position +1, phase -1)
//   cmd_steps[15:0]       step count, 0 allowed
//   cmd_speed[2:0]        speed code, 0 fastest .. 7 slowest
//   abort                 stop the current move
//   pos_clr               clear position (wins over a coincident step)
//   coil[3:0]             L1L2L3L4 drive pattern
//   busy                  move in progress
//   done                  one-cycle pulse at the end of every accepted command
//   aborted               qualifies done: move ended by abort
//   position[15:0]        signed step position, wraps modulo 2^16
//
// Build option: define STEPSEQ_RAMP_EN for a trapezoidal speed ramp
// (moves start and end at speed 7). Without it every step uses the
// commanded speed and the ramp logic is not built.

module stepmotor_seq #(
    parameter int BASE_TICKS = 10,
    parameter bit HOLD       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_steps,
    input  logic [2:0]  cmd_speed,
    input  logic        abort,
    input  logic        pos_clr,
    output logic [3:0]  coil,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] position
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] pos_q, pos_d;
    logic        dir_q, dir_d;
    logic [2:0]  speed_q, speed_d;
    logic        abrt_q, abrt_d;
    logic [3:0]  coil_q, coil_d;
    logic        expire;
    logic        last_step;
`ifdef STEPSEQ_RAMP_EN
    logic [15:0] idx_q, idx_d;
`endif

    function automatic logic [3:0] pattern(input logic [1:0] ph);
        logic [3:0] p;
        unique case (ph)
            2'd0: p = 4'b1001;
            2'd1: p = 4'b0011;
            2'd2: p = 4'b0110;
            2'd3: p = 4'b1100;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    // Timer reload value: one period minus the edge on which the step fires.
    function automatic logic [15:0] reload(input logic [2:0] code);
        return 16'(BASE_TICKS * (int'(code) + 1) - 1);
    endfunction

`ifdef STEPSEQ_RAMP_EN
    // Effective speed code for step k when `rest` steps follow it:
    // max(speed, 7 - min(k, rest)), floored at 0.
    function automatic logic [2:0] ramp_code(
        input logic [2:0]  s,
        input logic [15:0] k,
        input logic [15:0] rest
    );
        logic [15:0] d;
        logic [2:0]  r;
        d = (k < rest) ? k : rest;
        if (d >= 16'd7) begin
            r = s;
        end else begin
            r = 3'd7 - d[2:0];
            if (r < s) begin
                r = s;
            end
        end
        return r;
    endfunction
`endif

    assign expire    = (timer_q == 16'd0);
    assign last_step = (rem_q == 16'd1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        abrt_d  = abrt_q;
`ifdef STEPSEQ_RAMP_EN
        idx_d   = idx_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    speed_d = cmd_speed;
                    rem_d   = cmd_steps;
                    abrt_d  = 1'b0;
`ifdef STEPSEQ_RAMP_EN
                    idx_d   = 16'd0;
                    timer_d = reload(ramp_code(cmd_speed, 16'd0,
                                               cmd_steps - 16'd1));
`else
                    timer_d = reload(cmd_speed);
`endif
                    if (cmd_steps == 16'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = MOVE;
                    end
                end
            end

            MOVE: begin
                // An abort landing on the final step's expiry lets the
                // move complete normally.
                if (abort && !(expire && last_step)) begin
                    state_d = FIN;
                    abrt_d  = 1'b1;
                end else if (!expire) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    if (dir_q) begin
                        phase_d = phase_q - 2'd1;
                        pos_d   = pos_q + 16'd1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        pos_d   = pos_q - 16'd1;
                    end
                    rem_d = rem_q - 16'd1;
`ifdef STEPSEQ_RAMP_EN
                    idx_d   = idx_q + 16'd1;
                    timer_d = reload(ramp_code(speed_q, idx_q + 16'd1,
                                               rem_q - 16'd2));
`else
                    timer_d = reload(speed_q);
`endif
                    if (last_step) begin
                        state_d = FIN;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (pos_clr) begin
            pos_d = 16'd0;
        end

        // Coil is registered from next-state values so it changes on the
        // same edge as the phase, and reads 0000 out of reset.
        if (state_d == IDLE && !HOLD) begin
            coil_d = 4'b0000;
        end else begin
            coil_d = pattern(phase_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            rem_q   <= 16'd0;
            phase_q <= 2'd0;
            pos_q   <= 16'd0;
            dir_q   <= 1'b0;
            speed_q <= 3'd0;
            abrt_q  <= 1'b0;
            coil_q  <= 4'b0000;
`ifdef STEPSEQ_RAMP_EN
            idx_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            abrt_q  <= abrt_d;
            coil_q  <= coil_d;
`ifdef STEPSEQ_RAMP_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q == MOVE);
    assign done      = (state_q == FIN);
    assign aborted   = (state_q == FIN) && abrt_q;
    assign coil      = coil_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_stepmotor_seq.sv
// tb_stepmotor_seq: directed and randomized moves against a timeline model.
// Two instances: BASE_TICKS=10/HOLD=1 (main) and BASE_TICKS=1/HOLD=0 (b).

module tb_stepmotor_seq;

    localparam int BT  = 10;
    localparam int BTB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [2:0]  cmd_speed = '0;
    logic        abort = 1'b0;
    logic        pos_clr = 1'b0;
    logic [3:0]  coil;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] position;

    logic        valid_b = 1'b0;
    logic        ready_b;
    logic        dir_b = 1'b0;
    logic [15:0] steps_b = '0;
    logic [2:0]  speed_b = '0;
    logic        abort_b = 1'b0;
    logic        clr_b = 1'b0;
    logic [3:0]  coil_b;
    logic        busy_b;
    logic        done_b;
    logic        aborted_b;
    logic [15:0] pos_b;

    int checks = 0;
    int errors = 0;

    int          m_phase = 0;
    logic [15:0] m_pos = '0;
    int          mb_phase = 0;
    logic [15:0] mb_pos = '0;

    always #5 clk = ~clk;

    stepmotor_seq #(.BASE_TICKS(BT), .HOLD(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_speed(cmd_speed),
        .abort(abort), .pos_clr(pos_clr),
        .coil(coil), .busy(busy), .done(done),
        .aborted(aborted), .position(position)
    );

    stepmotor_seq #(.BASE_TICKS(BTB), .HOLD(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_dir(dir_b), .cmd_steps(steps_b), .cmd_speed(speed_b),
        .abort(abort_b), .pos_clr(clr_b),
        .coil(coil_b), .busy(busy_b), .done(done_b),
        .aborted(aborted_b), .position(pos_b)
    );

    function automatic logic [3:0] tab(input int p);
        logic [3:0] r;
        case (p)
            0: r = 4'b1001;
            1: r = 4'b0011;
            2: r = 4'b0110;
            default: r = 4'b1100;
        endcase
        return r;
    endfunction

    // Period in clocks of step k (0-based) of an n-step move.
    function automatic int period(input int base, input int k,
                                  input int n, input int s);
        int e;
`ifdef STEPSEQ_RAMP_EN
        e = 7 - ((k < n - 1 - k) ? k : n - 1 - k);
        if (e < 0) e = 0;
        if (e < s) e = s;
`else
        e = s;
`endif
        return base * (e + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic m_step(input bit d);
        if (d) begin
            m_pos   = m_pos + 16'd1;
            m_phase = (m_phase + 3) % 4;
        end else begin
            m_pos   = m_pos - 16'd1;
            m_phase = (m_phase + 1) % 4;
        end
    endtask

    // One command on the main instance, checked every cycle.
    // abort_at / clr_at: cycle offset after the accept edge, -1 for none.
    task automatic run_move(input bit d, input int n, input int s,
                            input int abort_at, input int clr_at);
        int  c;
        int  k;
        int  cum;
        bit  fin;
        bit  ab;
        bit  last;
        chk("ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = n[15:0];
        cmd_speed = s[2:0];
        tick();
        cmd_valid = 1'b0;
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_abrt", aborted, 0);
            chk("zero_busy", busy, 0);
            chk("zero_coil", coil, tab(m_phase));
            chk("zero_pos", position, m_pos);
            tick();
            chk("zero_done2", done, 0);
            chk("zero_ready", cmd_ready, 1);
            return;
        end
        chk("acc_busy", busy, 1);
        chk("acc_ready", cmd_ready, 0);
        k   = 0;
        c   = 0;
        cum = period(BT, 0, n, s);
        fin = 0;
        ab  = 0;
        while (!fin) begin
            c++;
            abort     = (c == abort_at);
            pos_clr   = (c == clr_at);
            cmd_valid = 1'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_steps = 16'($urandom);
            cmd_speed = 3'($urandom);
            tick();
            abort     = 1'b0;
            pos_clr   = 1'b0;
            cmd_valid = 1'b0;
            last = (k == n - 1);
            if (c == abort_at && !(c == cum && last)) begin
                fin = 1;
                ab  = 1;
            end else if (c == cum) begin
                m_step(d);
                k++;
                if (k == n) fin = 1;
                else cum += period(BT, k, n, s);
            end
            if (c == clr_at) m_pos = '0;
            if (!fin) begin
                chk("mv_busy", busy, 1);
                chk("mv_done", done, 0);
            end else begin
                chk("fin_done", done, 1);
                chk("fin_busy", busy, 0);
                chk("fin_abrt", aborted, ab);
            end
            chk("mv_coil", coil, tab(m_phase));
            chk("mv_pos", position, m_pos);
        end
        tick();
        chk("end_done", done, 0);
        chk("end_ready", cmd_ready, 1);
        chk("end_coil", coil, tab(m_phase));
        chk("end_pos", position, m_pos);
    endtask

    // One command on instance b, waiting for done within a cycle budget.
    task automatic move_b(input bit d, input int n, input int s);
        int w;
        chk("b_ready", ready_b, 1);
        valid_b = 1'b1;
        dir_b   = d;
        steps_b = n[15:0];
        speed_b = s[2:0];
        tick();
        valid_b = 1'b0;
        w = 0;
        while (done_b !== 1'b1 && w < n * 8 + 10) begin
            tick();
            w++;
        end
        chk("b_done", done_b, 1);
        for (int i = 0; i < n; i++) begin
            if (d) begin
                mb_pos   = mb_pos + 16'd1;
                mb_phase = (mb_phase + 3) % 4;
            end else begin
                mb_pos   = mb_pos - 16'd1;
                mb_phase = (mb_phase + 1) % 4;
            end
        end
        chk("b_fin_coil", coil_b, tab(mb_phase));
        chk("b_pos", pos_b, mb_pos);
        tick();
        chk("b_idle_coil", coil_b, 0);
        chk("b_idle_ready", ready_b, 1);
    endtask

    initial begin
        int          tot;
        int          n;
        int          s;
        int          aa;
        int          cc;
        logic [15:0] p0;

        // Reset values
        repeat (3) tick();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_coil", coil, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abrt", aborted, 0);
        chk("rst_pos", position, 0);
        rst = 1'b0;
        #1;
        chk("post_ready", cmd_ready, 1);
        chk("post_coil", coil, 0);
        tick();
        chk("hold_coil", coil, 4'b1001);
        chk("nohold_coil", coil_b, 0);

        // Directed moves
        run_move(1'b1, 4, 0, -1, -1);
        chk("fwd4_pos", position, 16'd4);
        run_move(1'b0, 3, 7, -1, -1);
        chk("rev3_pos", position, 16'd1);
        run_move(1'b1, 0, 3, -1, -1);

        // Abort one cycle after the third step
        p0 = m_pos;
        aa = period(BT, 0, 100, 2) + period(BT, 1, 100, 2)
           + period(BT, 2, 100, 2) + 1;
        run_move(1'b1, 100, 2, aa, -1);
        chk("abort_pos", position, p0 + 16'd3);

        // Abort on the final step's expiry completes normally
        aa = period(BT, 0, 2, 0) + period(BT, 1, 2, 0);
        run_move(1'b0, 2, 0, aa, -1);

        // pos_clr coincident with the first step
        run_move(1'b1, 3, 1, -1, period(BT, 0, 3, 1));

        // Ramp profile move
        run_move(1'b1, 20, 0, -1, -1);

        // Randomized moves
        for (int i = 0; i < 10; i++) begin
            n   = $urandom_range(0, 12);
            s   = $urandom_range(0, 7);
            tot = 0;
            for (int k = 0; k < n; k++) tot += period(BT, k, n, s);
            aa = -1;
            cc = -1;
            if (n > 0 && $urandom_range(0, 2) == 0) aa = $urandom_range(1, tot);
            if (n > 0 && $urandom_range(0, 3) == 0) cc = $urandom_range(1, tot);
            run_move(1'($urandom), n, s, aa, cc);
        end

        // Reset in the middle of a move: no done pulse
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_steps = 16'd5;
        cmd_speed = 3'd0;
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_pos", position, 0);
        chk("mrst_coil", coil, 0);
        rst = 1'b0;
        m_phase  = 0;
        m_pos    = '0;
        mb_phase = 0;
        mb_pos   = '0;
        tick();
        chk("mrst_done2", done, 0);
        chk("mrst_coil2", coil, 4'b1001);

        // Instance b: wrap, idle clear and 0x7FFF -> 0x8000
        move_b(1'b0, 2, 0);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        mb_pos = '0;
        chk("b_clr_pos", pos_b, 0);
        move_b(1'b1, 32767, 0);
        chk("b_7fff", pos_b, 16'h7FFF);
        move_b(1'b1, 1, 3);
        chk("b_8000", pos_b, 16'h8000);
        move_b(1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepmotor_seq.md
# stepmotor_seq

Move-command sequencer for the 4-phase unipolar stepper (28BYJ-48 class). It accepts move commands (direction, step count, speed code) over a valid/ready handshake and times each step. It drives the L1..L4 coil pattern directly, tracks signed absolute position and reports completion or abort. It sits between the control FSM or CPU register block and the motor driver pins, replacing free-running speed/enable control with counted moves.

## Interface
- BASE_TICKS, 10: clk cycles per speed unit; step period P = BASE_TICKS*(speed+1) clocks.
- HOLD, 1: 1 = coils keep last pattern while idle; 0 = coils 4'b0000 while idle.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  move command present.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready.
- cmd_dir  in  1  1 = forward (position +1, phase -1), 0 = reverse (position -1, phase +1).
- cmd_steps  in  16  number of steps, 0..65535.
- cmd_speed  in  3  speed code s; 0 = fastest, 7 = slowest.
- abort  in  1  stop current move at next clock edge.
- pos_clr  in  1  clear position counter.
- coil  out  4  L1L2L3L4 pattern.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse at end of every accepted command.
- aborted  out  1  valid with done; 1 if the move ended by abort.
- position  out  16  signed two's-complement step position; wraps modulo 2^16.

## Operation
- Phase table: 0=1001, 1=0011, 2=0110, 3=1100. Phase wraps 3<->0.
- States:
  - IDLE: cmd_ready=1. On accept: latch dir/steps/speed, load timer with P-1, go MOVE. If cmd_steps==0, go FIN without stepping.
  - MOVE: timer decrements each clk. At 0: advance phase, update position, decrement remaining, reload timer. If remaining hits 0, go FIN.
  - FIN: done=1 for one cycle, busy=0, go IDLE.
- Latched command fields are frozen during MOVE; cmd_* inputs are ignored while busy.
- abort in MOVE: no further step, go FIN with aborted=1. abort in IDLE/FIN is ignored.
- abort in the same cycle as the final step's timer expiry: the step executes and aborted=0.
- pos_clr has priority over a simultaneous step: position=0 and that step is not counted. Coil and phase still advance.
- Coil output: in MOVE/FIN, coil = table[phase]. In IDLE, coil = table[phase] if HOLD=1, else 0000.
- Phase and position persist across commands. Only rst or pos_clr clears position.
- Arithmetic: timer width is 16 bits; BASE_TICKS*8 must be <= 65536. Remaining count is 16 bits and never underflows.

## Timing
- Reset values (while rst=1 and on the first cycle after): state IDLE, phase 0, position 0, busy 0, done 0, aborted 0, cmd_ready 0 during rst, coil 0000 regardless of HOLD.
- Accept at edge t0; busy=1 from t0+1.
- Step k (1..N) updates coil and position at edge t0+k*P.
- Final step at t0+N*P; done=1 and busy=0 during cycle t0+N*P+1; cmd_ready=1 from t0+N*P+2.
- cmd_steps=0: done at t0+1, no coil change.
- abort sampled at edge ta: done at ta+1, with no step at ta.
- rst mid-move: immediate return to reset values; no done pulse.

## Configuration
- STEPSEQ_RAMP_EN defined: trapezoidal speed ramp. For step k (0-based) of N, the effective speed code is max(speed, 7-min(k, N-1-k)) clamped to 0..7, and period P_k uses that code. The move starts and ends at speed 7 and reaches the target after at most 7 steps.
- STEPSEQ_RAMP_EN undefined: constant P for every step. The ramp logic is absent.

## Test plan
- Reset, then cmd dir=1 steps=4 speed=0 (BASE_TICKS=10) -> coil 1001→1100→0110→0011→1001 at t0+10/20/30/40; position=4; done at t0+41.
- dir=0 steps=3 speed=7 -> steps every 80 clk; phase goes 0→1→2→3; position=-3; done at t0+241.
- steps=0 -> done=1 at t0+1, aborted=0, coil and position unchanged.
- steps=100 speed=2, abort at 3rd expiry edge -> that step executes; abort one cycle later -> done with aborted=1, position=+3.
- position=0x7FFF, forward 1 step -> 0x8000. pos_clr coincident with a step -> position 0; HOLD=0 idle -> coil 0000.
- With STEPSEQ_RAMP_EN, steps=20 speed=0 -> periods 80,70,…,10 (steps 0..7), 10 for steps 7..12, then 20,…,80; without the macro, all periods are 10.
